// File: rtl/alu_pkg.sv
// Purpose: shared ALU types: serial add/sub FSM states and add/sub mode encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/nbit_adder.sv
// Purpose: N-bit ripple adder with carry in/out; one chunk of the serial add/sub.
// Latency: combinational.
// Backpressure: none (pure logic).
module nbit_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Full-width sum, one extra bit captures the carry out of the MSB.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/addsub_serial.sv
// Purpose: handshaked N-bit add/sub, CHUNK bits per cycle, carry/ovf/zero/neg flags; ADDSUB_SAT_EN adds signed saturation.
// Latency: accepted at edge k, out_valid after edge k+C (C = N/CHUNK); one op per C+2 cycles.
// Backpressure: in_ready only in IDLE; DONE holds result and flags while out_ready is low.
module addsub_serial
    import alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         addn_sub,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int C     = N / CHUNK;
    localparam int IDX_W = (C > 1) ? $clog2(C) : 1;

    // Width must split evenly into chunks.
    generate
        if ((CHUNK < 1) || (N % CHUNK != 0)) begin : g_bad_chunk
            $error("addsub_serial: N must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;          // B already inverted for subtract
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N-1:0]       s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
`ifdef ADDSUB_SAT_EN
    logic               sat_q, sat_d;
`else
    logic               unused_sat;
    assign unused_sat = sat;
`endif

    logic [CHUNK-1:0]   a_chunk, b_chunk, sum_chunk;
    logic               carry_chunk;
    logic [N-1:0]       s_merged;
    logic [N-1:0]       s_final;
    logic               ovf_w;
    logic               last_chunk;

    assign last_chunk = (idx_q == IDX_W'(C - 1));

    // Select the operand slices for the current chunk index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < C; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    nbit_adder #(.N(CHUNK)) u_chunk_add (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (sum_chunk),
        .cout (carry_chunk)
    );

    // Result with the current chunk's sum merged in; on the last chunk this is the full wrapped result.
    always_comb begin
        s_merged = s_q;
        for (int i = 0; i < C; i++) begin
            if (idx_q == IDX_W'(i)) begin
                s_merged[i*CHUNK +: CHUNK] = sum_chunk;
            end
        end
    end

    // Signed overflow of the wrapped result and the (optionally saturated) final value.
    always_comb begin
        ovf_w   = (a_q[N-1] == b_q[N-1]) && (s_merged[N-1] != a_q[N-1]);
        s_final = s_merged;
`ifdef ADDSUB_SAT_EN
        if (sat_q && ovf_w) begin
            s_final = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    // FSM next state: accept in IDLE, step chunks in BUSY, wait for consumer in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake signals decode directly from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: latch operands on accept, add one chunk per BUSY cycle, finalise flags on the last.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
`ifdef ADDSUB_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {N{addn_sub}};
                    carry_d = (addn_sub == SUB);
                    idx_d   = '0;
`ifdef ADDSUB_SAT_EN
                    sat_d   = sat;
`endif
                end
            end
            BUSY: begin
                carry_d = carry_chunk;
                if (last_chunk) begin
                    s_d    = s_final;
                    cout_d = carry_chunk;
                    ovf_d  = ovf_w;
                    zero_d = (s_final == '0);
                    neg_d  = s_final[N-1];
                end else begin
                    s_d    = s_merged;
                    idx_d  = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
`ifdef ADDSUB_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
`ifdef ADDSUB_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign neg  = neg_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Purpose: bench for addsub_serial at CHUNK=4, CHUNK=N and CHUNK=1 against an integer-arithmetic model.
// Latency: checks out_valid arrives exactly N/CHUNK edges after accept.
// Backpressure: holds out_ready low in DONE and checks outputs stay put and new requests are ignored.
module tb_addsub_serial;

    localparam int N  = 8;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [N-1:0] a_in      [ND];
    logic [N-1:0] b_in      [ND];
    logic         addn_sub  [ND];
    logic         sat       [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [N-1:0] s         [ND];
    logic         cout      [ND];
    logic         ovf       [ND];
    logic         zero      [ND];
    logic         neg       [ND];

    int n_asrt = 0;
    int n_fail = 0;

    function automatic int chunk_of(input int d);
        case (d)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            localparam int CH = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
            addsub_serial #(.N(N), .CHUNK(CH)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .a         (a_in[g]),
                .b         (b_in[g]),
                .addn_sub  (addn_sub[g]),
                .sat       (sat[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .s         (s[g]),
                .cout      (cout[g]),
                .ovf       (ovf[g]),
                .zero      (zero[g]),
                .neg       (neg[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned integer arithmetic straight from the operation's definition.
    task automatic model(input logic [7:0] ai, input logic [7:0] bi, input logic sub, input logic sat_i,
                         output logic [7:0] se, output logic co, output logic ov,
                         output logic ze, output logic ne);
        int sa, sb, res, ua, ub;
        sa  = $signed(ai);
        sb  = $signed(bi);
        ua  = int'(ai);
        ub  = int'(bi);
        res = sub ? (sa - sb) : (sa + sb);
        ov  = (res > 127) || (res < -128);
        co  = sub ? (ua >= ub) : ((ua + ub) > 255);
        se  = sub ? 8'(ua - ub) : 8'(ua + ub);
`ifdef ADDSUB_SAT_EN
        if (sat_i && ov) se = (res > 127) ? 8'h7F : 8'h80;
`else
        if (sat_i) se = se;
`endif
        ze  = (se == 8'h00);
        ne  = se[7];
    endtask

    task automatic check_idle_reset(input int d, input string tag);
        chk({tag, "_in_ready"},  32'(in_ready[d]),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid[d]), 32'd0);
        chk({tag, "_s"},         32'(s[d]),         32'd0);
        chk({tag, "_cout"},      32'(cout[d]),      32'd0);
        chk({tag, "_ovf"},       32'(ovf[d]),       32'd0);
        chk({tag, "_zero"},      32'(zero[d]),      32'd0);
        chk({tag, "_neg"},       32'(neg[d]),       32'd0);
    endtask

    // One operation: accept, measure latency, check result, optionally stall in DONE with a competing request.
    task automatic run_op(input int d, input logic [7:0] ai, input logic [7:0] bi,
                          input logic sub, input logic sat_i, input int hold, input bit spam);
        logic [7:0] se;
        logic co, ov, ze, ne;
        int cyc;
        model(ai, bi, sub, sat_i, se, co, ov, ze, ne);
        chk("rdy_before_accept", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        a_in[d]     = ai;
        b_in[d]     = bi;
        addn_sub[d] = sub;
        sat[d]      = sat_i;
        out_ready[d] = 1'b0;
        step();
        in_valid[d] = 1'b0;
        chk("rdy_busy", 32'(in_ready[d]), 32'd0);
        cyc = 0;
        while (!out_valid[d] && cyc < 50) begin
            step();
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(N / chunk_of(d)));
        chk("s",    32'(s[d]),    32'(se));
        chk("cout", 32'(cout[d]), 32'(co));
        chk("ovf",  32'(ovf[d]),  32'(ov));
        chk("zero", 32'(zero[d]), 32'(ze));
        chk("neg",  32'(neg[d]),  32'(ne));
        for (int h = 0; h < hold; h++) begin
            if (spam) begin
                in_valid[d] = 1'b1;
                a_in[d]     = ~ai;
                b_in[d]     = 8'h11;
                addn_sub[d] = ~sub;
            end
            step();
            chk("hold_valid", 32'(out_valid[d]), 32'd1);
            chk("hold_s",     32'(s[d]),         32'(se));
            chk("hold_cout",  32'(cout[d]),      32'(co));
            if (spam) chk("hold_in_ready", 32'(in_ready[d]), 32'd0);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
        chk("drain_valid", 32'(out_valid[d]), 32'd0);
        chk("drain_ready", 32'(in_ready[d]),  32'd1);
        if (spam) begin
            step();
            chk("spam_not_taken", 32'(in_ready[d]), 32'd1);
        end
    endtask

    task automatic reset_mid_busy(input int d, input int busy_cycles);
        in_valid[d] = 1'b1;
        a_in[d]     = 8'h5A;
        b_in[d]     = 8'h33;
        addn_sub[d] = 1'b0;
        sat[d]      = 1'b0;
        step();
        in_valid[d] = 1'b0;
        repeat (busy_cycles) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle_reset(d, "abort");
        for (int i = 0; i < N / chunk_of(d) + 2; i++) begin
            step();
            chk("abort_no_valid", 32'(out_valid[d]), 32'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            a_in[d]      = '0;
            b_in[d]      = '0;
            addn_sub[d]  = 1'b0;
            sat[d]       = 1'b0;
            out_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) step();
        for (int d = 0; d < ND; d++) check_idle_reset(d, "reset");
        rst_n = 1'b1;
        step();

        // Directed vectors on the CHUNK=4 instance.
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(0, 8'h03, 8'h05, 1'b1, 1'b0, 0, 1'b0);
        run_op(0, 8'h05, 8'h05, 1'b1, 1'b0, 0, 1'b0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 0, 1'b0);
        run_op(0, 8'h80, 8'h01, 1'b1, 1'b0, 0, 1'b0);
        run_op(0, 8'h80, 8'h80, 1'b0, 1'b1, 0, 1'b0);
        run_op(0, 8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0);

        // Back-pressure: consumer stalls 5 cycles while a new request is waved at the block.
        run_op(0, 8'hC3, 8'h2D, 1'b1, 1'b0, 5, 1'b1);

        // Reset during BUSY aborts the op, then the block works normally.
        reset_mid_busy(0, 0);
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0);
        reset_mid_busy(2, 3);
        run_op(2, 8'h9C, 8'h71, 1'b1, 1'b1, 0, 1'b0);

        // Random regression on all three chunk widths.
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < 40; k++) begin
                run_op(d, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 2)), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
